// File: rtl/mano_bus_sequencer_pkg.sv
// Shared definitions for the basic-computer bus sequencer.
//   - Common-bus source indices (one-hot select bit positions / encoded select values).
//   - DMA grant FSM state encoding.
package bus_pkg;

    localparam int SRC_NONE = 0;
    localparam int SRC_AR   = 1;
    localparam int SRC_PC   = 2;
    localparam int SRC_DR   = 3;
    localparam int SRC_AC   = 4;
    localparam int SRC_IR   = 5;
    localparam int SRC_TR   = 6;
    localparam int SRC_MEM  = 7;

    typedef enum logic [1:0] {
        RUN     = 2'd0,
        GRANT   = 2'd1,
        RELEASE = 2'd2
    } dma_state_e;

endpackage

// File: rtl/mano_bus_sequencer_seq_counter.sv
// Sequence counter (SC) with one-hot timing decode.
// Ports:
//   clk    in  rising-edge clock
//   rst    in  asynchronous active-high reset, SC -> 0
//   freeze in  hold SC unconditionally (outranks clr)
//   clr    in  SC -> 0 on the next edge
//   hold   in  hold SC (lower priority than clr)
//   t      out one-hot decode of SC, t[k] set when SC == k
module seq_counter #(
    parameter int SC_W = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 freeze,
    input  logic                 clr,
    input  logic                 hold,
    output logic [2**SC_W-1:0]   t
);

    logic [SC_W-1:0] sc;

    // Natural binary wrap takes 2**SC_W-1 back to 0.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)         sc <= '0;
        else if (freeze) sc <= sc;
        else if (clr)    sc <= '0;
        else if (hold)   sc <= sc;
        else             sc <= sc + 1'b1;
    end

    always_comb begin
        t     = '0;
        t[sc] = 1'b1;
    end

endmodule

// File: rtl/mano_bus_sequencer.sv
// Basic-computer bus sequencer: owns SC/T, derives the common-bus source select
// from T, D, I and R, reports multi-source conflicts and arbitrates the bus to DMA.
// Ports:
//   clk, rst        clock, asynchronous active-high reset
//   D[7:0]          decoded opcode (one-hot)
//   I, R            indirect bit, interrupt flip-flop
//   clr_sc, hlt     clear / freeze the sequence counter
//   dma_req         external bus request (level)
//   T[NT-1:0]       one-hot timing vector
//   sel_oh[NSRC-1:0] one-hot bus select, bit 0 = no source
//   sel[SEL_W-1:0]  encoded bus select, highest requesting source wins
//   conflict        two or more sources requested
//   dma_gnt         bus granted to DMA
// Assumes SC_W >= 3 and SEL_W >= 3 so T4..T6 and source 7 exist.
module mano_bus_sequencer
    import bus_pkg::*;
#(
    parameter  int SC_W   = 4,
    parameter  int SEL_W  = 3,
    parameter  int DMA_EN = 1,
    localparam int NT     = 2**SC_W,
    localparam int NSRC   = 2**SEL_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [7:0]        D,
    input  logic              I,
    input  logic              R,
    input  logic              clr_sc,
    input  logic              hlt,
    input  logic              dma_req,
    output logic [NT-1:0]     T,
    output logic [NSRC-1:0]   sel_oh,
    output logic [SEL_W-1:0]  sel,
    output logic              conflict,
    output logic              dma_gnt
);

    dma_state_e      state, state_nxt;
    logic            run;
    logic            rn;
    logic [NSRC-1:0] req;
    int unsigned     nreq;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= RUN;
        else     state <= state_nxt;
    end

    // Grants are taken only at an instruction boundary: T0 active or SC being cleared.
    always_comb begin
        state_nxt = state;
        case (state)
            RUN:     if ((DMA_EN != 0) && dma_req && (T[0] || clr_sc)) state_nxt = GRANT;
            GRANT:   if (!dma_req) state_nxt = RELEASE;
            RELEASE: state_nxt = RUN;
            default: state_nxt = RUN;
        endcase
    end

    assign run     = (state == RUN);
    assign dma_gnt = (state == GRANT);
    assign rn      = ~R;

    // SC is frozen while DMA owns the bus; clr_sc and hlt only act in RUN.
    seq_counter #(.SC_W(SC_W)) u_seq_counter (
        .clk    (clk),
        .rst    (rst),
        .freeze (!run),
        .clr    (clr_sc),
        .hold   (hlt),
        .t      (T)
    );

    always_comb begin
        req = '0;
        if (run) begin
            req[SRC_AR]  = (D[4] & T[4]) | (D[5] & T[5]);
            req[SRC_PC]  = (D[5] & T[4]) | (T[0] & rn);
            req[SRC_DR]  = D[6] & T[6];
            req[SRC_AC]  = D[3] & T[4];
            req[SRC_IR]  = T[2] & rn;
            req[SRC_TR]  = R & T[1];
            req[SRC_MEM] = (rn & T[1]) | (~D[7] & I & T[3]) | ((D[0] | D[1] | D[2]) & T[4]);
        end
    end

    // Ascending scan so the highest requesting index is the one left in sel.
    always_comb begin
        sel  = '0;
        nreq = 0;
        for (int i = 1; i < NSRC; i++) begin
            if (req[i]) begin
                sel  = SEL_W'(i);
                nreq = nreq + 1;
            end
        end
        conflict    = (nreq > 1);
        sel_oh      = '0;
        sel_oh[sel] = 1'b1;
    end

endmodule

// File: tb/tb_mano_bus_sequencer.sv
module tb_mano_bus_sequencer;

    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  D;
    logic        I, R, clr_sc, hlt, dma_req;
    logic [15:0] T;
    logic [7:0]  sel_oh;
    logic [2:0]  sel;
    logic        conflict, dma_gnt;

    mano_bus_sequencer #(.SC_W(4), .SEL_W(3), .DMA_EN(1)) dut (
        .clk      (clk),
        .rst      (rst),
        .D        (D),
        .I        (I),
        .R        (R),
        .clr_sc   (clr_sc),
        .hlt      (hlt),
        .dma_req  (dma_req),
        .T        (T),
        .sel_oh   (sel_oh),
        .sel      (sel),
        .conflict (conflict),
        .dma_gnt  (dma_gnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] t;
        logic [2:0]  sel;
        logic [7:0]  oh;
        logic        conf;
        logic        gnt;
        string       name;
    } exp_t;

    exp_t q[$];
    int   n_tests = 0;
    int   n_fail  = 0;
    event sample_ev;

    task automatic push(input string nm, input int sc, input int s, input logic c, input logic g);
        exp_t e;
        e.t    = 16'd1 << sc;
        e.sel  = 3'(s);
        e.oh   = 8'd1 << s;
        e.conf = c;
        e.gnt  = g;
        e.name = nm;
        q.push_back(e);
    endtask

    // One clock: wait for the edge, drive this cycle's inputs, queue the expected outputs.
    task automatic step(input logic [7:0] d, input logic i_, input logic r_, input logic clr,
                        input logic h, input logic rq, input int sc, input int s,
                        input logic c, input logic g, input string nm);
        @(posedge clk);
        #1;
        D = d; I = i_; R = r_; clr_sc = clr; hlt = h; dma_req = rq;
        push(nm, sc, s, c, g);
    endtask

    // Monitor: compares the oldest expectation whenever outputs are sampled.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk or sample_ev);
            if (q.size() > 0) begin
                e = q.pop_front();
                n_tests++;
                if (T !== e.t || sel !== e.sel || sel_oh !== e.oh ||
                    conflict !== e.conf || dma_gnt !== e.gnt) begin
                    n_fail++;
                    $display("FAIL %s: got T=%h sel=%0d sel_oh=%h conflict=%b dma_gnt=%b, expected T=%h sel=%0d sel_oh=%h conflict=%b dma_gnt=%b",
                             e.name, T, sel, sel_oh, conflict, dma_gnt,
                             e.t, e.sel, e.oh, e.conf, e.gnt);
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int s;
        rst = 1'b1; D = '0; I = 0; R = 0; clr_sc = 0; hlt = 0; dma_req = 0;
        #1;
        push("reset", 0, 2, 0, 0);
        @(negedge clk);
        #1 rst = 1'b0;

        // Free run through all 16 states and wrap.
        for (int k = 1; k <= 16; k++) begin
            s = (k == 1) ? 7 : (k == 2) ? 5 : (k == 16) ? 2 : 0;
            step(8'h00, 0, 0, 0, 0, 0, k % 16, s, 0, 0, "walk");
        end

        // D5 (BUN-style): PC at T4, AR at T5, clear back to T0.
        step(8'h20, 0, 0, 0, 0, 0, 1, 7, 0, 0, "d5_t1");
        step(8'h20, 0, 0, 0, 0, 0, 2, 5, 0, 0, "d5_t2");
        step(8'h20, 0, 0, 0, 0, 0, 3, 0, 0, 0, "d5_t3");
        step(8'h20, 0, 0, 0, 0, 0, 4, 2, 0, 0, "d5_t4_pc");
        step(8'h20, 0, 0, 1, 0, 0, 5, 1, 0, 0, "d5_t5_ar");
        step(8'h20, 0, 0, 0, 0, 0, 0, 2, 0, 0, "clr_t0");

        // Interrupt cycle TR at T1, then D4 at T4.
        step(8'h00, 0, 1, 0, 0, 0, 1, 6, 0, 0, "r_t1_tr");
        step(8'h00, 0, 1, 0, 0, 0, 2, 0, 0, 0, "r_t2");
        step(8'h00, 0, 1, 0, 0, 0, 3, 0, 0, 0, "r_t3");
        step(8'h10, 0, 1, 1, 0, 0, 4, 1, 0, 0, "d4_t4_ar");

        // Illegal D0|D5 at T4 gives a conflict; hlt holds T4 for a cycle.
        step(8'h21, 0, 0, 0, 0, 0, 0, 2, 0, 0, "ill_t0");
        step(8'h21, 0, 0, 0, 0, 0, 1, 7, 0, 0, "ill_t1");
        step(8'h21, 0, 0, 0, 0, 0, 2, 5, 0, 0, "ill_t2");
        step(8'h21, 1, 0, 0, 0, 0, 3, 7, 0, 0, "ind_t3_mem");
        step(8'h21, 0, 0, 0, 1, 0, 4, 7, 1, 0, "ill_t4_conflict");
        step(8'h21, 0, 0, 0, 0, 0, 4, 7, 1, 0, "hlt_held_t4");
        step(8'h21, 0, 0, 1, 0, 0, 5, 1, 0, 0, "ill_t5_ar");

        // DMA request raised mid-instruction waits for the T0 boundary.
        step(8'h00, 0, 0, 0, 0, 0, 0, 2, 0, 0, "dma_t0");
        step(8'h00, 0, 0, 0, 0, 0, 1, 7, 0, 0, "dma_t1");
        step(8'h00, 0, 0, 0, 0, 1, 2, 5, 0, 0, "req_t2_nogrant");
        for (int k = 3; k <= 15; k++)
            step(8'h00, 0, 0, 0, 0, 1, k, 0, 0, 0, "req_wait");
        step(8'h00, 0, 0, 0, 0, 1, 0, 2, 0, 0, "req_t0_nogrant");
        for (int j = 0; j < 5; j++)
            step(8'h00, 0, 0, (j == 2), (j == 3), 1, 1, 0, 0, 1, "grant_frozen");
        step(8'h00, 0, 0, 0, 0, 0, 1, 0, 0, 1, "grant_drop_req");
        step(8'h00, 0, 0, 0, 0, 1, 1, 0, 0, 0, "release");
        step(8'h00, 0, 0, 0, 0, 1, 1, 7, 0, 0, "resume_t1");
        step(8'h00, 0, 0, 0, 0, 0, 2, 5, 0, 0, "no_regrant");

        // Boundary via clr_sc together with hlt: grant wins, SC cleared.
        step(8'h00, 0, 0, 1, 1, 1, 3, 0, 0, 0, "clr_hlt_req");
        step(8'h00, 0, 0, 0, 0, 1, 0, 0, 0, 1, "grant_after_clr");

        // Asynchronous reset in the middle of a grant cycle.
        @(negedge clk);
        #2;
        rst = 1'b1; dma_req = 0;
        #1;
        push("rst_async", 0, 2, 0, 0);
        -> sample_ev;
        @(posedge clk);
        #1 rst = 1'b0;
        step(8'h00, 0, 0, 0, 0, 0, 1, 7, 0, 0, "after_rst_t1");

        repeat (3) @(negedge clk);
        if (q.size() != 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL drain: %0d expectations left, expected 0", q.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
